// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: result buffer between the execute units and register_file.
// Holds up to DEPTH pending writes, drains the head onto the regW* port one per
// cycle, and offers two bypass lookups over everything still queued.
module reg_writeback_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      wb_hold,
    output logic [SEL_W-1:0]          regWSel,
    output logic [DATA_W-1:0]         regWData,
    output logic                      regWWe,
    input  logic [SEL_W-1:0]          rd1Sel,
    output logic                      byp1Hit,
    output logic [DATA_W-1:0]         byp1Data,
    input  logic [SEL_W-1:0]          rd2Sel,
    output logic                      byp2Hit,
    output logic [DATA_W-1:0]         byp2Data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              not_empty;
    logic              push;
    logic              pop;
    entry_t            head;

    // Handshake, head presentation and push/pop decode.
    always_comb begin
        not_empty = (cnt != '0);
        in_ready  = (cnt != CNT_W'(DEPTH));
        head      = mem[rd_ptr];
        regWWe    = not_empty && !wb_hold;
        regWSel   = not_empty ? head.sel  : '0;
        regWData  = not_empty ? head.data : '0;
        // Writes to the zero register complete the handshake but are dropped.
        push      = in_valid && in_ready && (in_sel != '0);
        pop       = regWWe;
    end

    assign count = cnt;

    // Pointer and occupancy bookkeeping; count separates full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; validity is derived from count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{sel: in_sel, data: in_data};
        end
    end

    // Bypass search, oldest to newest so the newest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        entry_t           e;
        byp1Hit  = 1'b0;
        byp1Data = '0;
        byp2Hit  = 1'b0;
        byp2Data = '0;
        idx      = '0;
        e        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            e   = mem[idx];
            if (CNT_W'(i) < cnt) begin
                if ((rd1Sel != '0) && (e.sel == rd1Sel)) begin
                    byp1Hit  = 1'b1;
                    byp1Data = e.data;
                end
                if ((rd2Sel != '0) && (e.sel == rd2Sel)) begin
                    byp2Hit  = 1'b1;
                    byp2Data = e.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: stimulus pushes expected writes,
// a negedge monitor checks every regWWe beat against them in order.
module tb_reg_writeback_queue;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 5;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  in_sel;
    logic [DATA_W-1:0] in_data;
    logic              wb_hold;
    logic [SEL_W-1:0]  regWSel;
    logic [DATA_W-1:0] regWData;
    logic              regWWe;
    logic [SEL_W-1:0]  rd1Sel;
    logic              byp1Hit;
    logic [DATA_W-1:0] byp1Data;
    logic [SEL_W-1:0]  rd2Sel;
    logic              byp2Hit;
    logic [DATA_W-1:0] byp2Data;
    logic [2:0]        count;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .wb_hold(wb_hold),
        .regWSel(regWSel), .regWData(regWData), .regWWe(regWWe),
        .rd1Sel(rd1Sel), .byp1Hit(byp1Hit), .byp1Data(byp1Data),
        .rd2Sel(rd2Sel), .byp2Hit(byp2Hit), .byp2Data(byp2Data),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every write beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && regWWe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_sel", 64'(regWSel), 64'hFFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_sel", 64'(regWSel), 64'(w.sel));
                check("wr_data", 64'(regWData), 64'(w.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] data);
        int k;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            check("push_timeout", 64'(in_ready), 64'd1);
        end else begin
            if (sel != '0) exp_q.push_back('{sel: sel, data: data});
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        while (count != 0 && k < 50) begin
            tick();
            k++;
        end
        check(name, 64'(count), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0;
        wb_hold = 1'b0; rd1Sel = '0; rd2Sel = '0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_we", 64'(regWWe), 64'd0);
        check("rst_sel", 64'(regWSel), 64'd0);
        check("rst_data", 64'(regWData), 64'd0);
        check("rst_hit", 64'({byp1Hit, byp2Hit}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single write, minimum latency
        push(5'd3, 32'h11);
        check("single_we", 64'(regWWe), 64'd1);
        check("single_count", 64'(count), 64'd1);
        tick();
        check("single_popped", 64'(count), 64'd0);
        check("single_we_off", 64'(regWWe), 64'd0);

        // Fill while held, stall, then release
        wb_hold = 1'b1;
        push(5'd1, 32'h101);
        push(5'd2, 32'h202);
        push(5'd3, 32'h303);
        push(5'd4, 32'h404);
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        check("full_we", 64'(regWWe), 64'd0);
        in_valid = 1'b1; in_sel = 5'd9; in_data = 32'h909;
        tick();
        tick();
        check("stall_count", 64'(count), 64'd4);
        wb_hold = 1'b0;
        #1;
        check("release_we", 64'(regWWe), 64'd1);
        check("release_sel", 64'(regWSel), 64'd1);
        tick();
        check("first_pop_count", 64'(count), 64'd3);
        check("first_pop_ready", 64'(in_ready), 64'd1);
        exp_q.push_back('{sel: 5'd9, data: 32'h909});
        tick();
        in_valid = 1'b0;
        check("push_pop_count", 64'(count), 64'd3);
        wait_empty("drain_full");

        // Bypass: newest match wins, head is searched
        wb_hold = 1'b1;
        push(5'd7, 32'hC);
        push(5'd5, 32'hA);
        push(5'd5, 32'hB);
        rd1Sel = 5'd5; rd2Sel = 5'd6;
        #1;
        check("byp1_hit", 64'(byp1Hit), 64'd1);
        check("byp1_data", 64'(byp1Data), 64'hB);
        check("byp2_miss", 64'(byp2Hit), 64'd0);
        check("byp2_miss_data", 64'(byp2Data), 64'd0);
        rd2Sel = 5'd7;
        #1;
        check("byp2_head_hit", 64'(byp2Hit), 64'd1);
        check("byp2_head_data", 64'(byp2Data), 64'hC);
        rd1Sel = '0; rd2Sel = '0;
        wb_hold = 1'b0;
        wait_empty("drain_byp");

        // Zero register: accepted, dropped
        check("zero_ready", 64'(in_ready), 64'd1);
        push(5'd0, 32'hFF);
        check("zero_count", 64'(count), 64'd0);
        check("zero_we", 64'(regWWe), 64'd0);
        rd1Sel = '0;
        #1;
        check("zero_no_hit", 64'(byp1Hit), 64'd0);
        tick();
        check("zero_count2", 64'(count), 64'd0);

        // Streaming push+pop across pointer wrap
        push(5'd1, 32'h1055);
        for (int i = 1; i <= 3 * DEPTH; i++) begin
            push(SEL_W'((i % 31) + 1), DATA_W'(i * 32'h1000 + 32'h55));
            check("stream_count", 64'(count), 64'd1);
        end
        wait_empty("drain_stream");

        // Reset while draining
        wb_hold = 1'b1;
        push(5'd10, 32'hA0A);
        push(5'd11, 32'hB0B);
        push(5'd12, 32'hC0C);
        wb_hold = 1'b0;
        tick();
        reset = 1'b1;
        exp_q.delete();
        rd1Sel = 5'd11; rd2Sel = 5'd12;
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_we", 64'(regWWe), 64'd0);
        check("midrst_hit", 64'({byp1Hit, byp2Hit}), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("post_rst_count", 64'(count), 64'd0);
        check("post_rst_hit", 64'({byp1Hit, byp2Hit}), 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
